// File: rtl/msg_uart_pkg.sv
// Shared types and constants for the status-message UART transmitter.
// MSG_UART_TX_NEWLINE_EN appends a line feed to every message.
package msg_uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StFinish
  } msg_state_e;

  localparam logic [7:0] ASCII_F    = 8'h46;
  localparam logic [7:0] ASCII_I    = 8'h49;
  localparam logic [7:0] ASCII_M    = 8'h4D;
  localparam logic [7:0] ASCII_E    = 8'h45;
  localparam logic [7:0] ASCII_N    = 8'h4E;
  localparam logic [7:0] ASCII_D    = 8'h44;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam logic [4:0] CODE_END = 5'd31;

`ifdef MSG_UART_TX_NEWLINE_EN
  localparam int unsigned FIM_LEN = 9;
  localparam int unsigned END_LEN = 6;
`else
  localparam int unsigned FIM_LEN = 8;
  localparam int unsigned END_LEN = 5;
`endif

  localparam logic [3:0] FIM_LAST = 4'(FIM_LEN - 1);
  localparam logic [3:0] END_LAST = 4'(END_LEN - 1);

  // Character at position idx of the message for code; positions past the body yield LF.
  function automatic logic [7:0] msg_char(input logic [4:0] code, input logic [3:0] idx);
    logic [7:0] tens;
    logic [4:0] units;
    logic [7:0] ch;
    if (code >= 5'd30) begin
      tens  = 8'd3;
      units = code - 5'd30;
    end else if (code >= 5'd20) begin
      tens  = 8'd2;
      units = code - 5'd20;
    end else if (code >= 5'd10) begin
      tens  = 8'd1;
      units = code - 5'd10;
    end else begin
      tens  = 8'd0;
      units = code;
    end
    if (code == CODE_END) begin
      case (idx)
        4'd0:    ch = ASCII_E;
        4'd1:    ch = ASCII_N;
        4'd2:    ch = ASCII_D;
        4'd3:    ch = ASCII_DASH;
        4'd4:    ch = ASCII_HASH;
        default: ch = ASCII_LF;
      endcase
    end else begin
      case (idx)
        4'd0:    ch = ASCII_F;
        4'd1:    ch = ASCII_I;
        4'd2:    ch = ASCII_M;
        4'd3:    ch = ASCII_DASH;
        4'd4:    ch = ASCII_ZERO + tens;
        4'd5:    ch = ASCII_ZERO + {3'd0, units};
        4'd6:    ch = ASCII_DASH;
        4'd7:    ch = ASCII_HASH;
        default: ch = ASCII_LF;
      endcase
    end
    return ch;
  endfunction

endpackage

// File: rtl/msg_uart_tx_if.sv
// Code strobe and UART status bundle between the code selector (master)
// and the message transmitter (slave).
interface msg_uart_tx_if;
  logic [4:0] code;
  logic       code_valid;
  logic       tx;
  logic       busy;
  logic       msg_done;
  logic       drop;

  modport master (
    output code, code_valid,
    input  tx, busy, msg_done, drop
  );

  modport slave (
    input  code, code_valid,
    output tx, busy, msg_done, drop
  );
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// o_byte_done is high in the last cycle of the stop bit so the next byte can follow at once.
module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [7:0] i_byte_in,
  input  logic       i_byte_valid,
  output logic       o_byte_done,
  output logic       o_tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [9:0]       r_frame;
  logic             r_active;
  logic             r_tx;
  logic             w_bit_end;

  assign w_bit_end   = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign o_byte_done = r_active && w_bit_end && (r_bit == 4'd9);
  assign o_tx        = r_tx;

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_bit    <= '0;
      r_frame  <= '1;
      r_active <= 1'b0;
      r_tx     <= 1'b1;
    end else if (!r_active) begin
      if (i_byte_valid) begin
        r_frame  <= {1'b1, i_byte_in, 1'b0};
        r_tx     <= 1'b0;
        r_cnt    <= '0;
        r_bit    <= '0;
        r_active <= 1'b1;
      end
    end else if (w_bit_end) begin
      r_cnt <= '0;
      if (r_bit == 4'd9) begin
        r_active <= 1'b0;
      end else begin
        // Frame shifts right; bit 1 is the next bit to drive.
        r_frame <= {1'b1, r_frame[9:1]};
        r_tx    <= r_frame[1];
        r_bit   <= r_bit + 4'd1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/msg_uart_tx.sv
// Turns fault/end-of-run codes into ASCII UART messages with a one-deep pending slot.
// MSG_UART_TX_NEWLINE_EN (see msg_uart_pkg) appends a line feed to each message.
module msg_uart_tx
  import msg_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic          clk_50M,
  input  logic          reset,
  msg_uart_tx_if.slave  bus
);

  msg_state_e r_state;
  logic [3:0] r_idx;
  logic [4:0] r_code;
  logic       r_pend_valid;
  logic [4:0] r_pend_code;
  logic       r_busy;
  logic       r_msg_done;
  logic       r_drop;

  logic       w_strobe;
  logic       w_pend_valid_n;
  logic [4:0] w_pend_code_n;
  logic       w_drop_set;
  logic       w_last;
  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_byte_done;
  logic       w_tx;

  assign w_strobe     = bus.code_valid && (bus.code != 5'd0);
  assign w_byte       = msg_char(r_code, r_idx);
  assign w_byte_valid = (r_state == StLoad);
  assign w_last       = (r_code == CODE_END) ? (r_idx == END_LAST) : (r_idx == FIM_LAST);

  // End-of-run always wins the pending slot; a newer fault replaces an older fault.
  always_comb begin
    w_pend_valid_n = r_pend_valid;
    w_pend_code_n  = r_pend_code;
    w_drop_set     = 1'b0;
    if (w_strobe && (r_state != StIdle)) begin
      if (!r_pend_valid) begin
        w_pend_valid_n = 1'b1;
        w_pend_code_n  = bus.code;
      end else begin
        w_drop_set = 1'b1;
        if ((bus.code == CODE_END) || (r_pend_code != CODE_END)) begin
          w_pend_code_n = bus.code;
        end
      end
    end
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_code       <= '0;
      r_pend_valid <= 1'b0;
      r_pend_code  <= '0;
      r_busy       <= 1'b0;
      r_msg_done   <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_msg_done   <= 1'b0;
      r_drop       <= r_drop | w_drop_set;
      r_pend_valid <= w_pend_valid_n;
      r_pend_code  <= w_pend_code_n;
      unique case (r_state)
        StIdle: begin
          if (w_strobe) begin
            r_code  <= bus.code;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: r_state <= StSend;
        StSend: begin
          if (w_byte_done) begin
            if (w_last) begin
              r_state    <= StFinish;
              r_msg_done <= 1'b1;
              r_busy     <= w_pend_valid_n;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= StLoad;
            end
          end
        end
        StFinish: begin
          if (w_pend_valid_n) begin
            r_code       <= w_pend_code_n;
            r_pend_valid <= 1'b0;
            r_idx        <= '0;
            r_busy       <= 1'b1;
            r_state      <= StLoad;
          end else begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .i_byte_in   (w_byte),
    .i_byte_valid(w_byte_valid),
    .o_byte_done (w_byte_done),
    .o_tx        (w_tx)
  );

  assign bus.tx       = w_tx;
  assign bus.busy     = r_busy;
  assign bus.msg_done = r_msg_done;
  assign bus.drop     = r_drop;

endmodule

// File: tb/tb_msg_uart_tx.sv
// Directed bench for msg_uart_tx: a free-running UART receiver collects bytes,
// each scenario task compares them against hand-written message strings.
module tb_msg_uart_tx;

  localparam int unsigned C = 4;

  logic clk_50M = 1'b0;
  logic reset;

  msg_uart_tx_if bus ();

  msg_uart_tx #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk_50M(clk_50M),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_50M = ~clk_50M;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rst_cnt = 0;
  string nl = "";
  logic [7:0] rx_q[$];
  int start_q[$];
  bit rx_active = 1'b0;

  always @(posedge clk_50M) cyc++;
  always @(negedge clk_50M) if (bus.msg_done === 1'b1) done_cnt++;
  always @(posedge reset) rst_cnt++;

  // Receiver: samples mid-bit; frames with a reset or a bad start/stop bit are discarded.
  initial begin : rx_proc
    logic [7:0] b;
    int st;
    int rc;
    bit bad;
    forever begin
      @(negedge clk_50M);
      if (reset === 1'b0 && bus.tx === 1'b0) begin
        rx_active = 1'b1;
        st = cyc;
        rc = rst_cnt;
        bad = 1'b0;
        repeat (C / 2) @(negedge clk_50M);
        if (bus.tx !== 1'b0) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk_50M);
          b[i] = bus.tx;
        end
        repeat (C) @(negedge clk_50M);
        if (bus.tx !== 1'b1 || rst_cnt != rc || reset !== 1'b0) bad = 1'b1;
        if (!bad) begin
          rx_q.push_back(b);
          start_q.push_back(st);
        end
        rx_active = 1'b0;
      end
    end
  end

  task automatic strobe(input logic [4:0] c);
    @(posedge clk_50M);
    #1;
    bus.code = c;
    bus.code_valid = 1'b1;
    @(posedge clk_50M);
    #1;
    bus.code_valid = 1'b0;
    bus.code = 5'h15;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50M);
      if (bus.busy === 1'b0 && !rx_active) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk_50M);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_50M);
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.msg_done !== 1'b0) begin errors++; $display("FAIL reset_msg_done: got %b want 0", bus.msg_done); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", bus.drop); end
    @(posedge clk_50M);
    #1 reset = 1'b0;
  endtask

  task automatic test_fim07();
    string s;
    int base, d0;
    bit ok;
    logic [7:0] got, exp;
    s = {"FIM-07-#", nl};
    base = rx_q.size();
    d0 = done_cnt;
    strobe(5'd7);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fim07_busy_c1: got %b want 1", bus.busy); end
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL fim07_tx_c1: got %b want 1", bus.tx); end
    @(posedge clk_50M);
    #1;
    checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL fim07_start_c2: got %b want 0", bus.tx); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL fim07_timeout: got busy %b want 0", bus.busy); end
    checks++;
    if (rx_q.size() - base != s.len()) begin
      errors++; $display("FAIL fim07_len: got %0d want %0d", rx_q.size() - base, s.len());
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00;
      exp = s[i];
      checks++; if (got !== exp) begin errors++; $display("FAIL fim07_char%0d: got %h want %h", i, got, exp); end
    end
    for (int i = 1; i < s.len(); i++) begin
      if (base + i < start_q.size()) begin
        checks++;
        if (start_q[base + i] - start_q[base + i - 1] > 10 * C + 1) begin
          errors++; $display("FAIL fim07_gap%0d: got %0d want <=%0d", i,
                             start_q[base + i] - start_q[base + i - 1], 10 * C + 1);
        end
      end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL fim07_msg_done: got %0d want 1", done_cnt - d0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fim07_busy_after: got %b want 0", bus.busy); end
  endtask

  task automatic test_end();
    string s;
    int base, d0;
    bit ok;
    logic [7:0] got, exp;
    s = {"END-#", nl};
    base = rx_q.size();
    d0 = done_cnt;
    strobe(5'd31);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL end_timeout: got busy %b want 0", bus.busy); end
    checks++;
    if (rx_q.size() - base != s.len()) begin
      errors++; $display("FAIL end_len: got %0d want %0d", rx_q.size() - base, s.len());
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00;
      exp = s[i];
      checks++; if (got !== exp) begin errors++; $display("FAIL end_char%0d: got %h want %h", i, got, exp); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL end_msg_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    string s;
    int base, d0;
    bit ok;
    logic [7:0] got, exp;
    s = {"FIM-12-#", nl, "END-#", nl};
    base = rx_q.size();
    d0 = done_cnt;
    strobe(5'd12);
    repeat (60) @(negedge clk_50M);
    strobe(5'd31);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy %b want 0", bus.busy); end
    checks++;
    if (rx_q.size() - base != s.len()) begin
      errors++; $display("FAIL b2b_len: got %0d want %0d", rx_q.size() - base, s.len());
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00;
      exp = s[i];
      checks++; if (got !== exp) begin errors++; $display("FAIL b2b_char%0d: got %h want %h", i, got, exp); end
    end
    for (int i = 1; i < s.len(); i++) begin
      if (base + i < start_q.size()) begin
        checks++;
        if (start_q[base + i] - start_q[base + i - 1] > 10 * C + 2) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d want <=%0d", i,
                             start_q[base + i] - start_q[base + i - 1], 10 * C + 2);
        end
      end
    end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_msg_done: got %0d want 2", done_cnt - d0); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b want 0", bus.drop); end
  endtask

  task automatic test_drop();
    string s;
    int base, d0;
    bit ok;
    logic [7:0] got, exp;
    s = {"FIM-03-#", nl, "END-#", nl};
    base = rx_q.size();
    d0 = done_cnt;
    strobe(5'd3);
    repeat (10) @(negedge clk_50M);
    strobe(5'd31);
    repeat (5) @(negedge clk_50M);
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL drop_before: got %b want 0", bus.drop); end
    strobe(5'd5);
    #1;
    checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL drop_set: got %b want 1", bus.drop); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL drop_timeout: got busy %b want 0", bus.busy); end
    checks++;
    if (rx_q.size() - base != s.len()) begin
      errors++; $display("FAIL drop_len: got %0d want %0d", rx_q.size() - base, s.len());
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00;
      exp = s[i];
      checks++; if (got !== exp) begin errors++; $display("FAIL drop_char%0d: got %h want %h", i, got, exp); end
    end
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL drop_msg_done: got %0d want 2", done_cnt - d0); end
    checks++; if (bus.drop !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b want 1", bus.drop); end
  endtask

  task automatic test_code0_and_30();
    string s;
    int base;
    bit ok, moved;
    logic [7:0] got, exp;
    base = rx_q.size();
    strobe(5'd0);
    moved = 1'b0;
    repeat (8) begin
      @(negedge clk_50M);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) moved = 1'b1;
    end
    checks++; if (moved) begin errors++; $display("FAIL code0_idle: got activity %b want 0", moved); end
    checks++; if (rx_q.size() != base) begin errors++; $display("FAIL code0_bytes: got %0d want 0", rx_q.size() - base); end
    s = {"FIM-30-#", nl};
    strobe(5'd30);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL fim30_timeout: got busy %b want 0", bus.busy); end
    checks++;
    if (rx_q.size() - base != s.len()) begin
      errors++; $display("FAIL fim30_len: got %0d want %0d", rx_q.size() - base, s.len());
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00;
      exp = s[i];
      checks++; if (got !== exp) begin errors++; $display("FAIL fim30_char%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid_msg();
    string s;
    int base, d0;
    bit ok;
    logic [7:0] got, exp;
    base = rx_q.size();
    strobe(5'd9);
    strobe(5'd20);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50M);
      if (rx_q.size() >= base + 2 && bus.tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_char3: got %0d bytes want 2", rx_q.size() - base); end
    @(negedge clk_50M);
    reset = 1'b1;
    #1;
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", bus.tx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got %b want 0", bus.drop); end
    repeat (3) @(negedge clk_50M);
    @(posedge clk_50M);
    #1 reset = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50M);
      if (!rx_active) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_rx_idle: got active %b want 0", rx_active); end
    s = {"FIM-01-#", nl};
    base = rx_q.size();
    d0 = done_cnt;
    strobe(5'd1);
    wait_idle(ok);
    repeat (100) @(negedge clk_50M);
    checks++; if (!ok) begin errors++; $display("FAIL fim01_timeout: got busy %b want 0", bus.busy); end
    checks++;
    if (rx_q.size() - base != s.len()) begin
      errors++; $display("FAIL fim01_len: got %0d want %0d", rx_q.size() - base, s.len());
    end
    for (int i = 0; i < s.len(); i++) begin
      got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'h00;
      exp = s[i];
      checks++; if (got !== exp) begin errors++; $display("FAIL fim01_char%0d: got %h want %h", i, got, exp); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL fim01_msg_done: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    reset = 1'b1;
    bus.code = 5'd0;
    bus.code_valid = 1'b0;
`ifdef MSG_UART_TX_NEWLINE_EN
    nl = "\n";
`endif
    test_reset();
    test_fim07();
    test_end();
    test_back_to_back();
    test_drop();
    test_code0_and_30();
    test_reset_mid_msg();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msg_uart_tx.md
# msg_uart_tx

Serialises status codes into ASCII messages over an 8N1 UART line to the base station. Sits directly downstream of the stop/code selector: it consumes the 5-bit code (fault/column number, or 5'b11111 for end of run) and emits either a fault-identification message or an end-of-run message. Holds one pending code so a strobe arriving mid-transmission is not lost.

## Interface
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2
- clk_50M  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- code  in  5  message code; 1..30 = fault number, 31 = end of run, 0 = no message
- code_valid  in  1  single-cycle strobe qualifying `code`
- tx  out  1  UART serial line, idle high
- busy  out  1  high while a message is being transmitted
- msg_done  out  1  one-cycle pulse after the stop bit of a message's last character
- drop  out  1  sticky; set when a pending code is discarded; cleared only by reset

## Operation
- Messages: code 1..30 → "FIM-NN-#" (NN two decimal digits, leading zero, e.g. 7 → "FIM-07-#", 8 chars); code 31 → "END-#" (5 chars); code 0 with code_valid → ignored, no state change.
- Digits: tens = 0..3 by compare against 10/20/30, units = code − 10·tens; ASCII = 8'h30 + digit.
- Character order: left to right; each byte LSB first, 1 start bit (0), 8 data, 1 stop bit (1).
- Message FSM: IDLE → LOAD (select char at index 0) → SEND (byte handed to serialiser, wait for byte_done) → LOAD next index or FINISH after last char → IDLE, or LOAD of the pending message if pending valid.
- Pending register (1 deep): strobe while busy with pending empty → store. Pending full: new code 31 overwrites any pending code; new fault code does not overwrite a pending 31 (new code dropped); fault over fault → overwrite. Every discard (new or old) sets drop.
- Strobe in IDLE and cycle of FINISH: FINISH-cycle strobe goes to pending, then sent immediately.
- Reset mid-message: tx returns high asynchronously, partial frame abandoned, pending cleared.
- Reset values: tx=1, busy=0, msg_done=0, drop=0, FSM IDLE, pending empty.

## Timing
- code_valid at cycle 0 in IDLE → busy=1 at cycle 1, tx falls (start bit) at cycle 2.
- Each bit held exactly CLKS_PER_BIT cycles; byte = 10·CLKS_PER_BIT cycles; consecutive characters back-to-back with at most 1 idle cycle between stop bit and next start bit.
- msg_done pulses in the cycle after the final stop bit completes; busy falls same cycle unless pending valid (busy stays high, next start bit ≤ 2 cycles later).
- code captured at strobe; later changes of `code` do not alter an accepted message.

## Configuration
- MSG_UART_TX_NEWLINE_EN defined: every message appended with 8'h0A ("FIM-NN-#\n" 9 chars, "END-#\n" 6 chars).
- Undefined: no terminator; lengths 8 and 5.

## Structure
- Shared package msg_uart_pkg: FSM state enum (IDLE, LOAD, SEND, FINISH), ASCII constants (F, I, M, E, N, D, '-', '#', LF, '0'), CODE_END = 5'd31, message length constants.
- Sub-module uart_byte_tx: byte_in, byte_valid, byte_done, tx; owns bit counter and CLKS_PER_BIT baud counter; the message FSM owns character index and pending logic.

## Test plan
- CLKS_PER_BIT=4, code=7 strobe in IDLE → tx decodes "FIM-07-#" (46 49 4D 2D 30 37 2D 23), start bit at cycle 2, one msg_done, busy low after.
- code=31 strobe → "END-#" (45 4E 44 2D 23); with MSG_UART_TX_NEWLINE_EN, trailing 0A and 6 chars.
- code=12 sent, code=31 strobed mid-frame → "FIM-12-#" then "END-#" with no line-idle gap >1 bit, two msg_done pulses, drop=0.
- While sending, pending=31, then strobe code=5 → code 5 dropped, drop=1, output "…END-#" only.
- code=0 with code_valid → tx stays 1, busy stays 0; code=30 → "FIM-30-#".
- Assert reset during 3rd character → tx=1, busy=0, drop=0 immediately; subsequent strobe code=1 → clean "FIM-01-#".
